// File: rtl/blake_round_ctrl.sv
// ----------------------------------------------------------------------------
// blake_round_ctrl
// Sequencer for the BLAKE-512 compression datapath. A block is accepted with a
// start handshake, init_round loads IV/state, the G-function core is stepped
// through NUM_ROUNDS rounds (column step then diagonal step), count_done tells
// the finalize stage to latch the digest, and out_valid is presented to the
// downstream consumer until it is taken.
//
// Parameters
//   NUM_ROUNDS      rounds per block, 1..16
//   STEPS_PER_ROUND G-steps per round, 1 or 2 (0 = column, 1 = diagonal)
//
// Ports
//   clk, rstb      clock, asynchronous active-low reset
//   start_valid/start_ready   block-start handshake (ready only in IDLE)
//   out_valid/out_ready       digest handshake (valid only in DONE)
//   init_round     one-cycle pulse in INIT
//   round_en       high every RUN cycle
//   round_idx      current round, sigma_idx = round_idx mod 10, step_sel
//   count_done     one-cycle pulse in FIN
//   busy           high in every state except IDLE
//   blk_count      (only with BLAKE_ROUND_CTRL_BLKCNT_EN) count of completed
//                  out handshakes, wraps at 2^32
//
// Optional feature macro: BLAKE_ROUND_CTRL_BLKCNT_EN
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, is held until that edge, and the
// producer's data is stable for the whole time valid is high.
// ----------------------------------------------------------------------------
module blake_round_ctrl #(
    parameter int NUM_ROUNDS      = 16,
    parameter int STEPS_PER_ROUND = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        init_round,
    output logic        round_en,
    output logic [3:0]  round_idx,
    output logic [3:0]  sigma_idx,
    output logic        step_sel,
`ifdef BLAKE_ROUND_CTRL_BLKCNT_EN
    output logic [31:0] blk_count,
`endif
    output logic        count_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic       LAST_STEP  = 1'(STEPS_PER_ROUND - 1);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] sigma_q, sigma_d;
    logic       step_q, step_d;
    logic       last_step;
    logic       last_round;

    assign last_step  = (step_q == LAST_STEP);
    assign last_round = (round_q == LAST_ROUND);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            sigma_q <= 4'd0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            sigma_q <= sigma_d;
            step_q  <= step_d;
        end
    end

    // Counters hold their values outside RUN so the last round/step stays
    // visible through FIN and DONE; they are only cleared when a block starts.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        sigma_d = sigma_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_INIT;
                    round_d = 4'd0;
                    sigma_d = 4'd0;
                    step_d  = 1'b0;
                end
            end
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (last_step) begin
                    if (last_round) begin
                        state_d = S_FIN;
                    end else begin
                        step_d  = 1'b0;
                        round_d = round_q + 4'd1;
                        // Running mod-10 counter instead of a divider.
                        sigma_d = (sigma_q == 4'd9) ? 4'd0 : sigma_q + 4'd1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_FIN:  state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: everything decodes from registered state and counters.
    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign init_round  = (state_q == S_INIT);
    assign round_en    = (state_q == S_RUN);
    assign count_done  = (state_q == S_FIN);
    assign out_valid   = (state_q == S_DONE);
    assign round_idx   = round_q;
    assign sigma_idx   = sigma_q;
    assign step_sel    = step_q;

`ifdef BLAKE_ROUND_CTRL_BLKCNT_EN
    logic [31:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (out_valid && out_ready) begin
            blk_d = blk_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            blk_q <= 32'd0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blk_count = blk_q;
`endif

endmodule
